// File: rtl/dir_pkg.sv
// rtl/dir_pkg.sv - shared types and default parameters for the direction selector
package dir_pkg;

   typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} dir_t;

   localparam int SYNC_STAGES_DEF = 2;
   localparam int DB_CYCLES_DEF   = 4;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - push-button synchroniser, debouncer and press-edge detector
module btn_debounce
   import dir_pkg::*;
#(
   parameter int SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int DB_CYCLES   = DB_CYCLES_DEF
) (
   input  logic clk,
   input  logic clrn,
   input  logic raw,
   output logic db,
   output logic press
);

   localparam int              CNT_W    = $clog2(DB_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync;
   logic [CNT_W-1:0]       cnt;
   logic                   s;
   logic                   db_prev;

   assign s = sync[SYNC_STAGES-1];

   // The counter only advances while s disagrees with db, so any glitch resets it.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         sync    <= '0;
         db      <= 1'b0;
         db_prev <= 1'b0;
         cnt     <= '0;
      end else begin
         sync    <= {sync[SYNC_STAGES-2:0], raw};
         db_prev <= db;
         if (s == db) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            db  <= s;
            cnt <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

   assign press = db & ~db_prev;

endmodule

// File: rtl/dir_select.sv
// rtl/dir_select.sv - two-button up/down direction selector with change pulse
module dir_select
   import dir_pkg::*;
#(
   parameter int SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int DB_CYCLES   = DB_CYCLES_DEF
) (
   input  logic clk,
   input  logic clrn,
   input  logic btn_up,
   input  logic btn_dn,
   output logic vec,
   output logic dir_chg
);

   logic       press_up;
   logic       press_dn;
   logic [1:0] db_lvl_unused;
   dir_t       state;
   dir_t       state_nxt;
   logic       chg_nxt;

   btn_debounce #(.SYNC_STAGES(SYNC_STAGES), .DB_CYCLES(DB_CYCLES)) u_db_up (
      .clk   (clk),
      .clrn  (clrn),
      .raw   (btn_up),
      .db    (db_lvl_unused[0]),
      .press (press_up)
   );

   btn_debounce #(.SYNC_STAGES(SYNC_STAGES), .DB_CYCLES(DB_CYCLES)) u_db_dn (
      .clk   (clk),
      .clrn  (clrn),
      .raw   (btn_dn),
      .db    (db_lvl_unused[1]),
      .press (press_dn)
   );

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state   <= DIR_DOWN;
         dir_chg <= 1'b0;
      end else begin
         state   <= state_nxt;
         dir_chg <= chg_nxt;
      end
   end

   // Simultaneous presses cancel; a press for the active direction is a no-op.
   always_comb begin
      state_nxt = state;
      chg_nxt   = 1'b0;
      if (state == DIR_DOWN) begin
         if (press_up && !press_dn) begin
            state_nxt = DIR_UP;
            chg_nxt   = 1'b1;
         end
      end else begin
         if (press_dn && !press_up) begin
            state_nxt = DIR_DOWN;
            chg_nxt   = 1'b1;
         end
      end
   end

   assign vec = state;

endmodule

// File: tb/tb_dir_select.sv
// tb/tb_dir_select.sv - randomized self-checking bench for dir_select
module tb_dir_select;

   localparam int SS = 2;
   localparam int DB = 4;

   logic clk = 1'b0;
   logic clrn = 1'b0;
   logic btn_up = 1'b0;
   logic btn_dn = 1'b0;
   logic vec;
   logic dir_chg;

   int total = 0;
   int passed = 0;

   dir_select #(.SYNC_STAGES(SS), .DB_CYCLES(DB)) dut (
      .clk     (clk),
      .clrn    (clrn),
      .btn_up  (btn_up),
      .btn_dn  (btn_dn),
      .vec     (vec),
      .dir_chg (dir_chg)
   );

   always #5 clk = ~clk;

   // Reference model: raw sample history gives the synchronised value, and a
   // debounced level flips once the last DB synchronised samples all disagree.
   bit hist_u[$], hist_d[$], sh_u[$], sh_d[$];
   bit m_db_u = 0, m_db_d = 0, m_dbp_u = 0, m_dbp_d = 0, m_vec = 0, m_chg = 0;
   bit pu, pd, su, sd;

   function automatic bit settled(input bit db, input bit q[$]);
      for (int i = 0; i < DB; i++)
         if (q[i] == db) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_reset();
      hist_u = {}; hist_d = {}; sh_u = {}; sh_d = {};
      for (int i = 0; i < SS; i++) begin hist_u.push_back(0); hist_d.push_back(0); end
      for (int i = 0; i < DB; i++) begin sh_u.push_back(0); sh_d.push_back(0); end
      m_db_u = 0; m_db_d = 0; m_dbp_u = 0; m_dbp_d = 0; m_vec = 0; m_chg = 0;
   endtask

   always @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         model_reset();
      end else begin
         pu = m_db_u && !m_dbp_u;
         pd = m_db_d && !m_dbp_d;
         m_chg = 0;
         if (pu && !pd && !m_vec) begin m_vec = 1; m_chg = 1; end
         else if (pd && !pu && m_vec) begin m_vec = 0; m_chg = 1; end
         m_dbp_u = m_db_u;
         m_dbp_d = m_db_d;
         su = hist_u[SS-1];
         sd = hist_d[SS-1];
         hist_u.push_front(btn_up); void'(hist_u.pop_back());
         hist_d.push_front(btn_dn); void'(hist_d.pop_back());
         sh_u.push_front(su); void'(sh_u.pop_back());
         sh_d.push_front(sd); void'(sh_d.pop_back());
         if (settled(m_db_u, sh_u)) m_db_u = su;
         if (settled(m_db_d, sh_d)) m_db_d = sd;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      repeat (4) @(negedge clk);
      total++;
      if (vec !== 1'b0 || dir_chg !== 1'b0)
         $display("FAIL reset_state: vec=%b dir_chg=%b expected 0/0", vec, dir_chg);
      else passed++;
      clrn = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         total++;
         if (vec !== 1'b0 || dir_chg !== 1'b0 || m_vec !== 1'b0)
            $display("FAIL reset_idle c%0d: vec=%b dir_chg=%b expected 0/0", i, vec, dir_chg);
         else passed++;
      end
   endtask

   task automatic test_clean_up();
      btn_up = 1'b1;
      for (int e = 1; e <= 10; e++) begin
         tick();
         total++;
         if (vec !== (e >= 7) || dir_chg !== (e == 7))
            $display("FAIL clean_up e%0d: vec=%b dir_chg=%b expected %b/%b",
                     e, vec, dir_chg, e >= 7, e == 7);
         else passed++;
      end
      btn_up = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         total++;
         if (vec !== m_vec || dir_chg !== m_chg)
            $display("FAIL clean_up_rel c%0d: vec=%b dir_chg=%b expected %b/%b", i, vec, dir_chg, m_vec, m_chg);
         else passed++;
      end
   endtask

   task automatic test_bounce();
      int pulses = 0;
      clrn = 1'b0;
      tick();
      clrn = 1'b1;
      tick();
      for (int i = 0; i < 20; i++) begin
         btn_up = (i < 10) ? ((i / 2) % 2 == 0) : 1'b1;
         tick();
         pulses += int'(dir_chg);
         total++;
         if (vec !== m_vec || dir_chg !== m_chg)
            $display("FAIL bounce c%0d: vec=%b dir_chg=%b expected %b/%b", i, vec, dir_chg, m_vec, m_chg);
         else passed++;
      end
      total++;
      if (pulses != 1 || vec !== 1'b1)
         $display("FAIL bounce_pulses: pulses=%0d vec=%b expected 1/1", pulses, vec);
      else passed++;
      btn_up = 1'b0;
      repeat (12) tick();
   endtask

   task automatic test_redundant_simul();
      for (int phase = 0; phase < 2; phase++) begin
         btn_up = 1'b1;
         btn_dn = (phase == 1);
         for (int i = 0; i < 12; i++) begin
            tick();
            total++;
            if (vec !== 1'b1 || dir_chg !== 1'b0)
               $display("FAIL redundant_simul p%0d c%0d: vec=%b dir_chg=%b expected 1/0", phase, i, vec, dir_chg);
            else passed++;
         end
         btn_up = 1'b0;
         btn_dn = 1'b0;
         repeat (12) tick();
      end
   endtask

   task automatic test_back_to_back();
      int pulses = 0;
      for (int i = 0; i < 42; i++) begin
         btn_dn = (i < 10);
         btn_up = (i >= 20 && i < 30);
         tick();
         pulses += int'(dir_chg);
         total++;
         if (vec !== m_vec || dir_chg !== m_chg)
            $display("FAIL down_up c%0d: vec=%b dir_chg=%b expected %b/%b", i, vec, dir_chg, m_vec, m_chg);
         else passed++;
      end
      total++;
      if (pulses != 2 || vec !== 1'b1)
         $display("FAIL down_up_pulses: pulses=%0d vec=%b expected 2/1", pulses, vec);
      else passed++;
   endtask

   task automatic test_reset_mid_press();
      btn_dn = 1'b1;
      repeat (3) tick();
      clrn = 1'b0;
      #1;
      total++;
      if (vec !== 1'b0 || dir_chg !== 1'b0)
         $display("FAIL mid_reset_async: vec=%b dir_chg=%b expected 0/0", vec, dir_chg);
      else passed++;
      repeat (2) tick();
      clrn = 1'b1;
      for (int i = 0; i < 14; i++) begin
         tick();
         total++;
         if (vec !== 1'b0 || dir_chg !== 1'b0)
            $display("FAIL mid_reset_hold c%0d: vec=%b dir_chg=%b expected 0/0", i, vec, dir_chg);
         else passed++;
      end
      btn_dn = 1'b0;
      repeat (12) tick();
   endtask

   task automatic test_random();
      int len_u = 0, len_d = 0;
      for (int i = 0; i < 1500; i++) begin
         if (len_u == 0) begin btn_up = $urandom_range(1, 0); len_u = $urandom_range(14, 1); end
         if (len_d == 0) begin btn_dn = $urandom_range(1, 0); len_d = $urandom_range(14, 1); end
         len_u--;
         len_d--;
         clrn = ($urandom_range(199, 0) != 0);
         tick();
         total++;
         if (vec !== m_vec || dir_chg !== m_chg)
            $display("FAIL random c%0d: vec=%b dir_chg=%b expected %b/%b", i, vec, dir_chg, m_vec, m_chg);
         else passed++;
      end
      clrn = 1'b1;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_clean_up();
      test_bounce();
      test_redundant_simul();
      test_back_to_back();
      test_reset_mid_press();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/dir_select.md
Name: dir_select

Overview:
- Upstream control stage for the lab's 3-bit up/down counters.
- Turns two raw push-buttons (UP, DOWN) into the counters' direction input `vec`: 0 = count down, 1 = count up.
- Each button is synchronised, debounced and edge-detected.
- A two-state FSM holds the current direction and emits a one-cycle pulse on every direction change.

Parameters:
- SYNC_STAGES, 2, flip-flops in each button synchroniser (legal range ≥ 2).
- DB_CYCLES, 4, consecutive stable synchronised cycles required before the debounced level changes (legal range ≥ 1).
- CNT_W, $clog2(DB_CYCLES+1), width of the debounce counter (derived, not overridden).

Ports:
- clk  input  1  single clock; all state updates on posedge.
- clrn  input  1  asynchronous active-low reset.
- btn_up  input  1  raw, asynchronous, bouncy UP button (1 = pressed).
- btn_dn  input  1  raw, asynchronous, bouncy DOWN button (1 = pressed).
- vec  output  1  direction to the counters: 0 = down, 1 = up; registered.
- dir_chg  output  1  one-cycle pulse, high in the cycle after `vec` changes value; registered.

Behaviour:
- Reset (clrn = 0, asynchronous, any time):
  - all synchroniser flops = 0;
  - debounced levels = 0, previous-level flops = 0, debounce counters = 0;
  - FSM = DIR_DOWN, so vec = 0; dir_chg = 0.
- Reset mid-operation aborts any press in progress; it is not replayed after release.
- Synchroniser: SYNC_STAGES-deep flop chain per button. `s` is the last stage.
- Debounce, per button, with debounced level `db` and counter `cnt`:
  - if s == db: cnt <= 0;
  - else if cnt == DB_CYCLES-1: db <= s, cnt <= 0;
  - else: cnt <= cnt+1.
  - Any glitch shorter than DB_CYCLES synchronised cycles leaves db unchanged and clears the count.
- Edge detect: db_prev <= db each cycle; press = db & ~db_prev (combinational). Release edges are ignored.
- FSM states: DIR_DOWN (vec = 0), DIR_UP (vec = 1). vec is the state register itself.
  - DIR_DOWN, press_up & ~press_dn -> DIR_UP, dir_chg <= 1.
  - DIR_UP, press_dn & ~press_up -> DIR_DOWN, dir_chg <= 1.
  - Press for the already-active direction: no change, dir_chg <= 0.
  - press_up & press_dn in the same cycle: both ignored, state held, dir_chg <= 0.
  - Otherwise dir_chg <= 0.
- Latency: raw button goes high and stays high before posedge 1. Then:
  - db rises at posedge SYNC_STAGES+DB_CYCLES (6 with defaults);
  - vec changes at posedge SYNC_STAGES+DB_CYCLES+1 (7);
  - dir_chg is high for exactly that one cycle.
- Holding a button does not retrigger. A new press requires a debounced release followed by a debounced press.
- Minimum press-to-press spacing for two accepted changes: 2*DB_CYCLES+2 cycles.
- The two buttons are fully independent until the FSM. One button bouncing does not delay the other.

Decomposition:
- Package dir_pkg:
  - enum dir_t {DIR_DOWN = 1'b0, DIR_UP = 1'b1};
  - localparam default constants SYNC_STAGES_DEF = 2, DB_CYCLES_DEF = 4.
- Sub-module btn_debounce (params SYNC_STAGES, DB_CYCLES; ports clk, clrn, raw, db, press):
  - contains the synchroniser, debounce counter and edge detect;
  - instantiated twice in dir_select.
- FSM and output registers stay in dir_select.

Test Plan:
- Reset then hold: clrn low for 4 negedges, then high, buttons idle -> vec = 0, dir_chg = 0 for 20 cycles.
- Clean UP press: btn_up = 1 held for 10 cycles -> vec goes 0->1 at the 7th posedge after first sampling, dir_chg high for exactly 1 cycle, no further pulses while held.
- Bounce rejection: btn_up toggled 1,0,1,0,1 with each level held 2 cycles, then held 1 for 10 cycles -> exactly one transition; vec = 1 only after 4 stable synchronised cycles; single dir_chg pulse.
- Redundant and simultaneous presses:
  - with vec = 1, press UP -> no change, dir_chg stays 0;
  - press UP and DOWN on the same edge, both held -> vec stays 1, dir_chg stays 0.
- DOWN then UP sequence: DOWN press -> vec 1->0 with one pulse; release; after 10 cycles UP press -> vec 0->1 with one pulse; exactly 2 pulses total.
- Reset mid-press: btn_dn high with vec = 1, clrn pulsed low at cycle 3 of the debounce window -> vec = 0 and dir_chg = 0 immediately. After clrn rises with btn_dn still held, a debounced DOWN press occurs but vec stays 0 and dir_chg stays 0, because the press matches the current direction.
